// File: rtl/psg_write_scheduler.sv
// Round-robin scheduler turning two requesters' logical commands into SN76489 latch/data byte writes.
// Define PSG_SHADOW_SKIP_EN to drop tone data bytes whose high bits match the last value written.
module psg_write_scheduler #(
  parameter int WRITE_GAP = 4,
  parameter int NUM_REQ   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_chan,
  input  logic [NUM_REQ-1:0]    req_attn,
  input  logic [10*NUM_REQ-1:0] req_value,
  output logic [7:0]            psg_data,
  output logic                  psg_we_n,
  output logic                  busy
);

`ifdef PSG_SHADOW_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  localparam logic [7:0] GAP_LOAD = 8'(WRITE_GAP - 1);

  typedef enum logic [1:0] {IDLE, LATCH, GAP, DATA} state_t;

  state_t     state;
  logic       ptr;
  logic [7:0] gap_cnt;
  logic [1:0] cmd_chan;
  logic [5:0] cmd_hi;
  logic       data_pend;
  logic [5:0] shadow [4];

  logic [1:0] grant;
  logic       sel;
  logic [1:0] s_chan;
  logic       s_attn;
  logic [9:0] s_val;
  logic       s_tone;
  logic       s_pend;
  logic [7:0] latch_byte;

  // Grant only in IDLE and never while reset is held.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !reset) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign sel       = grant[1];
  assign s_chan    = sel ? req_chan[3:2]    : req_chan[1:0];
  assign s_attn    = sel ? req_attn[1]      : req_attn[0];
  assign s_val     = sel ? req_value[19:10] : req_value[9:0];
  assign s_tone    = !s_attn && (s_chan != 2'd3);
  assign s_pend    = s_tone && !(SKIP_EN && (s_val[9:4] == shadow[s_chan]));
  assign busy      = (state != IDLE);

  always_comb begin
    if (s_attn)
      latch_byte = {1'b1, s_chan, 1'b1, s_val[3:0]};
    else if (s_chan == 2'd3)
      latch_byte = {5'b11100, s_val[2:0]};
    else
      latch_byte = {1'b1, s_chan, 1'b0, s_val[3:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      gap_cnt   <= 8'd0;
      cmd_chan  <= 2'd0;
      cmd_hi    <= 6'd0;
      data_pend <= 1'b0;
      psg_data  <= 8'h00;
      psg_we_n  <= 1'b1;
      for (int i = 0; i < 4; i++) shadow[i] <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            cmd_chan  <= s_chan;
            cmd_hi    <= s_val[9:4];
            data_pend <= s_pend;
            ptr       <= ~sel;
            psg_data  <= latch_byte;
            psg_we_n  <= 1'b0;
            state     <= LATCH;
          end
        end
        LATCH: begin
          psg_we_n <= 1'b1;
          gap_cnt  <= GAP_LOAD;
          state    <= GAP;
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            if (data_pend) begin
              data_pend        <= 1'b0;
              psg_data         <= {2'b00, cmd_hi};
              psg_we_n         <= 1'b0;
              shadow[cmd_chan] <= cmd_hi;
              state            <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DATA: begin
          psg_we_n <= 1'b1;
          gap_cnt  <= GAP_LOAD;
          state    <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_write_scheduler.sv
// Directed bench for psg_write_scheduler with a cycle-level strobe schedule model.
module tb_psg_write_scheduler;
  localparam int G = 4;

  logic        clk;
  logic        reset;
  logic        v0, v1;
  logic [1:0]  chn [2];
  logic        atn [2];
  logic [9:0]  vlu [2];
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_chan;
  logic [1:0]  req_attn;
  logic [19:0] req_value;
  logic [7:0]  psg_data;
  logic        psg_we_n;
  logic        busy;

  assign req_valid = {v1, v0};
  assign req_chan  = {chn[1], chn[0]};
  assign req_attn  = {atn[1], atn[0]};
  assign req_value = {vlu[1], vlu[0]};

  psg_write_scheduler #(.WRITE_GAP(G), .NUM_REQ(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_attn(req_attn), .req_value(req_value),
    .psg_data(psg_data), .psg_we_n(psg_we_n), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model state: expected strobe schedule as (cycle, byte) pairs.
  int qc[$];
  int qb[$];
  int busy_end = -1;
  int mptr = 0;
  int msh[4];
  int last_b = 0;
  int slog[$];
  int acc_cyc[$];
  int acc_req[$];
  int g, r, hi;
  bit eb, ewe, dd;

  function automatic int latch_of(input int ch, input int at, input int v);
    if (at != 0) return 128 + 16 + ch * 32 + (v % 16);
    if (ch == 3) return 224 + (v % 8);
    return 128 + ch * 32 + (v % 16);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      qc.delete(); qb.delete();
      busy_end = -1; mptr = 0; last_b = 0;
      for (int i = 0; i < 4; i++) msh[i] = 0;
    end
    eb  = (cyc <= busy_end);
    ewe = 1'b1;
    if (qc.size() > 0 && qc[0] == cyc) begin
      ewe = 1'b0;
      last_b = qb[0];
      void'(qc.pop_front());
      void'(qb.pop_front());
    end
    g = 0;
    if (!reset && !eb) begin
      if (v0 && !v1)      g = 1;
      else if (!v0 && v1) g = 2;
      else if (v0 && v1)  g = (mptr == 1) ? 2 : 1;
    end
    check("req_ready", 32'(req_ready), 32'(g));
    check("busy", 32'(busy), 32'(eb));
    check("psg_we_n", 32'(psg_we_n), 32'(ewe));
    check("psg_data", 32'(psg_data), 32'(last_b));
    if (psg_we_n === 1'b0) slog.push_back(int'(psg_data));
    if (g != 0) begin
      r = (g == 2) ? 1 : 0;
      acc_cyc.push_back(cyc);
      acc_req.push_back(r);
      mptr = 1 - r;
      qc.push_back(cyc + 1);
      qb.push_back(latch_of(int'(chn[r]), int'(atn[r]), int'(vlu[r])));
      busy_end = cyc + 1 + G;
      if (atn[r] == 1'b0 && chn[r] != 2'd3) begin
        hi = int'(vlu[r]) / 16;
        dd = 1'b1;
`ifdef PSG_SHADOW_SKIP_EN
        dd = (hi != msh[chn[r]]);
`endif
        if (dd) begin
          qc.push_back(cyc + 2 + G);
          qb.push_back(hi);
          busy_end = cyc + 2 + 2 * G;
          msh[chn[r]] = hi;
        end
      end
    end
  end

  task automatic issue(input int rq, input int ch, input int at, input int v, input int n);
    int got = 0;
    int t = 0;
    chn[rq] = 2'(ch); atn[rq] = 1'(at); vlu[rq] = 10'(v);
    if (rq == 0) v0 = 1'b1; else v1 = 1'b1;
    while (got < n && t < 300) begin
      @(negedge clk);
      t++;
      if (req_ready[rq]) begin
        @(posedge clk);
        got++;
        #1;
      end
    end
    if (rq == 0) v0 = 1'b0; else v1 = 1'b0;
    if (got < n) begin
      tests++; fails++;
      $display("FAIL accept timeout: requester %0d got %0d of %0d grants", rq, got, n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || qc.size() > 0) && t < 300);
    if (t >= 300) begin
      tests++; fails++;
      $display("FAIL idle timeout: busy=%0b, expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_seq(input string nm, input int n, input int b[6]);
    check({nm, " count"}, 32'(slog.size()), 32'(n));
    for (int i = 0; i < n && i < slog.size(); i++) check(nm, 32'(slog[i]), 32'(b[i]));
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic clear_logs();
    slog.delete(); acc_cyc.delete(); acc_req.delete();
  endtask

  initial begin
    reset = 1'b1; v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 2; i++) begin chn[i] = 2'd0; atn[i] = 1'b0; vlu[i] = 10'd0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset psg_data", 32'(psg_data), 32'h00);
    check("reset psg_we_n", 32'(psg_we_n), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    clear_logs();
    issue(0, 1, 1, 5, 2);
    wait_idle();
    check_seq("attn ch1 v5", 2, '{'hB5, 'hB5, 0, 0, 0, 0});
    check("attn spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(2 + G));

    clear_logs();
    issue(0, 0, 0, 'h3FE, 2);
    wait_idle();
    check_seq("tone ch0 3FE", 4, '{'h8E, 'h3F, 'h8E, 'h3F, 0, 0});
    check("tone spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(3 + 2 * G));

    clear_logs();
    issue(0, 3, 0, 4, 1);
    issue(1, 2, 0, 'h123, 1);
    wait_idle();
    check_seq("noise then tone ch2", 3, '{'hE4, 'hC3, 'h12, 0, 0, 0});

    do_reset();
    clear_logs();
    fork
      issue(0, 1, 0, 'h2A5, 2);
      issue(1, 2, 1, 'hA, 2);
    join
    wait_idle();
    check_seq("contention", 6, '{'hA5, 'h2A, 'hDA, 'hA5, 'h2A, 'hDA});
    check("grant count", 32'(acc_req.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_req.size(); i++) check("grant order", 32'(acc_req[i]), 32'(i % 2));

    clear_logs();
    issue(0, 0, 0, 'h3FE, 1);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset psg_we_n", 32'(psg_we_n), 32'd1);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset psg_data", 32'(psg_data), 32'h00);
    @(posedge clk); #1 reset = 1'b0;
    wait_idle();
    check_seq("dropped tone", 1, '{'h8E, 0, 0, 0, 0, 0});
    clear_logs();
    issue(0, 2, 0, 'h123, 1);
    wait_idle();
    check_seq("after reset tone", 2, '{'hC3, 'h12, 0, 0, 0, 0});

    do_reset();
    clear_logs();
    issue(0, 0, 0, 'h005, 1);
    wait_idle();
    issue(0, 0, 0, 'h015, 1);
    wait_idle();
`ifdef PSG_SHADOW_SKIP_EN
    check_seq("shadow skip", 3, '{'h85, 'h85, 'h01, 0, 0, 0});
`else
    check_seq("shadow noskip", 4, '{'h85, 'h00, 'h85, 'h01, 0, 0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
